// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 8N1 UART receiver feeding a small circular FIFO that the CPU
// drains with a level-based request/acknowledge handshake.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit
//   FIFO_DEPTH    receive FIFO entries (power of two, 2..16)
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   i_Rx_Serial   asynchronous UART line (idle high, LSB first)
//   i_Rd_Req      CPU request level: rise = request, fall = acknowledge
//   o_Rd_Byte     byte delivered to the CPU (holds last value after ack)
//   o_Rd_Valid    o_Rd_Byte is valid for the current request
//   o_Fifo_Count  bytes currently held in the FIFO
//   o_Overrun     sticky: a received byte was dropped because the FIFO was full
//   o_Frame_Err   one-cycle pulse when a stop bit is sampled low
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 50,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    input  logic       i_Rd_Req,
    output logic [7:0] o_Rd_Byte,
    output logic       o_Rd_Valid,
    output logic [4:0] o_Fifo_Count,
    output logic       o_Overrun,
    output logic       o_Frame_Err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [4:0]    FULL_CNT = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    // ---------------------------------------------------------------
    // Line synchronizer (resets to idle-high so reset never looks like
    // a start bit)
    // ---------------------------------------------------------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    // ---------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------
    rx_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          push, ferr_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_Frame_Err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            o_Frame_Err <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Re-check mid start bit; a high line here was a glitch.
                if (cnt == HALF_BIT) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    // Shift in from the top: after 8 bits the first (LSB)
                    // lands in bit 0.
                    shreg_n = {rx_sync, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_sync) push   = 1'b1;
                    else         ferr_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FIFO and CPU handshake
    // ---------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          req_q, pending;
    logic          rd_rise, pop, full, push_ok;

    assign rd_rise = i_Rd_Req & ~req_q;
    // A request withdrawn before delivery must not consume a byte.
    assign pop     = pending & i_Rd_Req & (count != 5'd0);
    assign full    = (count == FULL_CNT);
    // A same-edge pop frees the slot, so a full FIFO still accepts.
    assign push_ok = push & (~full | pop);

    assign o_Fifo_Count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Overrun  <= 1'b0;
            req_q      <= 1'b0;
            pending    <= 1'b0;
            o_Rd_Byte  <= 8'h00;
            o_Rd_Valid <= 1'b0;
        end else begin
            req_q <= i_Rd_Req;

            if (!i_Rd_Req)    pending <= 1'b0;
            else if (rd_rise) pending <= 1'b1;
            else if (pop)     pending <= 1'b0;

            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);

            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase

            if (push & full & ~pop) o_Overrun <= 1'b1;

            if (pop) begin
                o_Rd_Byte  <= mem[rd_ptr];
                o_Rd_Valid <= 1'b1;
            end else if (!i_Rd_Req) begin
                o_Rd_Valid <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable
    // once count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int CPB   = 50;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rd_req = 1'b0;
    logic [7:0] rd_byte;
    logic       rd_valid;
    logic [4:0] fifo_count;
    logic       overrun;
    logic       frame_err;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_Rx_Serial  (rx),
        .i_Rd_Req     (rd_req),
        .o_Rd_Byte    (rd_byte),
        .o_Rd_Valid   (rd_valid),
        .o_Fifo_Count (fifo_count),
        .o_Overrun    (overrun),
        .o_Frame_Err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // scoreboard: bytes expected out of the FIFO, in order
    logic [7:0] exp_q[$];
    int         m_count = 0;

    // edge bookkeeping for latency / pulse-width checks
    int         cyc = 0;
    int         ferr_cnt = 0;
    int         cnt_up_cyc = 0;
    int         vld_up_cyc = 0;
    logic [4:0] prev_cnt = '0;
    logic       prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (fifo_count > prev_cnt) cnt_up_cyc <= cyc;
        if (rd_valid && !prev_vld) vld_up_cyc <= cyc;
        prev_cnt <= fifo_count;
        prev_vld <= rd_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
    endtask

    // send and update the scoreboard for a FIFO nobody is reading
    task automatic send_model(input logic [7:0] d, input logic stop_ok);
        send_byte(d, stop_ok);
        if (stop_ok && m_count < DEPTH) begin
            exp_q.push_back(d);
            m_count++;
        end
    endtask

    task automatic do_read(input string nm);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty, nothing to read", nm);
            return;
        end
        e = exp_q.pop_front();
        rd_req = 1'b1;
        tick(1);
        check({nm, "_vld_edge1"}, 32'(rd_valid), 32'd0);
        tick(1);
        check({nm, "_vld_edge2"}, 32'(rd_valid), 32'd1);
        check({nm, "_byte"}, 32'(rd_byte), 32'(e));
        m_count--;
        check({nm, "_count"}, 32'(fifo_count), 32'(m_count));
        // held-high request must not pop again
        tick(3);
        check({nm, "_hold_count"}, 32'(fifo_count), 32'(m_count));
        check({nm, "_hold_vld"}, 32'(rd_valid), 32'd1);
        rd_req = 1'b0;
        tick(1);
        check({nm, "_ack_vld"}, 32'(rd_valid), 32'd0);
        check({nm, "_ack_byte"}, 32'(rd_byte), 32'(e));
        tick(1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic [4:0] exp_count;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int f0;

        tbl[0] = '{8'h33, 1'b0, 5'd0, 1};
        tbl[1] = '{8'h34, 1'b1, 5'd1, 0};
        tbl[2] = '{8'hA5, 1'b1, 5'd2, 0};
        tbl[3] = '{8'h00, 1'b1, 5'd3, 0};
        tbl[4] = '{8'hFF, 1'b1, 5'd4, 0};
        tbl[5] = '{8'h3C, 1'b0, 5'd4, 1};

        // reset state
        tick(3);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_byte", 32'(rd_byte), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b1;
        tick(5);

        // basic delivery of 0x41
        send_model(8'h41, 1'b1);
        check("b41_count", 32'(fifo_count), 32'd1);
        do_read("b41");

        // table: good bytes and frame errors
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            send_model(tbl[i].data, tbl[i].stop_ok);
            check($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].exp_count));
            check($sformatf("tbl%0d_ferr", i), 32'(ferr_cnt - f0), 32'(tbl[i].exp_ferr));
        end
        for (int i = 0; i < 4; i++) do_read($sformatf("tbl_rd%0d", i));

        // glitch: short low pulse is rejected
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(2 * CPB);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // request withdrawn while empty: no later pop
        rd_req = 1'b1;
        tick(3);
        rd_req = 1'b0;
        tick(1);
        send_model(8'h66, 1'b1);
        check("cancel_count", 32'(fifo_count), 32'd1);
        check("cancel_vld", 32'(rd_valid), 32'd0);
        do_read("cancel");

        // pending request served the edge after the push
        rd_req = 1'b1;
        tick(3);
        check("pend_wait_vld", 32'(rd_valid), 32'd0);
        send_byte(8'h5A, 1'b1);
        check("pend_vld", 32'(rd_valid), 32'd1);
        check("pend_byte", 32'(rd_byte), 32'h5A);
        check("pend_count", 32'(fifo_count), 32'd0);
        check("pend_latency", 32'(vld_up_cyc - cnt_up_cyc), 32'd1);
        rd_req = 1'b0;
        tick(1);
        check("pend_ack_vld", 32'(rd_valid), 32'd0);

        // overrun: nine bytes into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            send_model(8'(i), 1'b1);
            if (i == 8) check("ovr_before", 32'(overrun), 32'd0);
        end
        check("ovr_count", 32'(fifo_count), 32'd8);
        check("ovr_flag", 32'(overrun), 32'd1);
        for (int i = 0; i < 8; i++) do_read($sformatf("ovr_rd%0d", i));
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_empty", 32'(fifo_count), 32'd0);

        // reset in the middle of bit 4 of 0x77
        fork
            send_byte(8'h77, 1'b1);
            begin
                tick(CPB * 5 + 25);
                rst = 1'b0;
                #2;
                check("mid_rst_count", 32'(fifo_count), 32'd0);
                check("mid_rst_valid", 32'(rd_valid), 32'd0);
                check("mid_rst_byte", 32'(rd_byte), 32'd0);
                check("mid_rst_overrun", 32'(overrun), 32'd0);
                check("mid_rst_ferr", 32'(frame_err), 32'd0);
            end
        join
        tick(2);
        rst = 1'b1;
        exp_q.delete();
        m_count = 0;
        tick(CPB);
        check("post_rst_count", 32'(fifo_count), 32'd0);
        send_model(8'h12, 1'b1);
        check("post_rst_count1", 32'(fifo_count), 32'd1);
        do_read("post_rst");
        check("post_rst_overrun", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 50, meaning clk cycles per UART bit (50 = 1 Mbaud at 50 MHz).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; the value SHALL be a power of two from 2 to 16.
REQ-003 SHALL provide port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL provide port rst, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL provide port i_Rx_Serial, input, 1, asynchronous UART line (8N1, idle high, LSB first).
REQ-006 SHALL provide port i_Rd_Req, input, 1, CPU input-request level: rise = request, fall = acknowledge.
REQ-007 SHALL provide port o_Rd_Byte, output, 8, byte delivered to the CPU.
REQ-008 SHALL provide port o_Rd_Valid, output, 1, o_Rd_Byte is valid for the current request.
REQ-009 SHALL provide port o_Fifo_Count, output, 5, number of bytes held in the FIFO.
REQ-010 SHALL provide port o_Overrun, output, 1, sticky flag: a byte was dropped because the FIFO was full.
REQ-011 SHALL provide port o_Frame_Err, output, 1, one-cycle pulse when a stop bit is sampled low.

Function
REQ-012 SHALL pass i_Rx_Serial through a 2-flop synchronizer reset to 1; all receiver logic uses the synchronized value.
REQ-013 SHALL implement the RX FSM with states IDLE, START, DATA, STOP and a bit counter of 0..CLKS_PER_BIT-1.
REQ-014 IDLE: the FSM SHALL move to START on a synchronized low and clear the counter.
REQ-015 START: at count (CLKS_PER_BIT-1)/2 the FSM SHALL go to DATA if the line is low, else to IDLE (glitch rejected, nothing pushed).
REQ-016 DATA: the FSM SHALL sample one bit every CLKS_PER_BIT cycles into bit index 0..7, LSB first, and go to STOP after bit 7.
REQ-017 STOP: after CLKS_PER_BIT cycles the FSM SHALL sample the line; high = push the byte, low = discard it and pulse o_Frame_Err; it then returns to IDLE.
REQ-018 Push SHALL occur on the same edge the stop bit is sampled; if count == FIFO_DEPTH the byte SHALL be dropped and o_Overrun set.
REQ-019 o_Overrun SHALL stay 1 until reset.
REQ-020 The FIFO SHALL be circular, with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH and a separate count register.
REQ-021 Request detection: a rising edge of i_Rd_Req (current high, registered previous low) SHALL set a pending flag.
REQ-022 Pending delivery: on any edge with pending = 1 and count > 0, the block SHALL pop the head into o_Rd_Byte, set o_Rd_Valid = 1 and clear pending.
REQ-023 Delivery latency SHALL be exactly 2 clk edges after i_Rd_Req is first sampled high when the FIFO is non-empty.
REQ-024 If the FIFO is empty, pending SHALL hold and delivery SHALL occur on the edge after the push edge.
REQ-025 o_Rd_Valid and o_Rd_Byte SHALL hold until i_Rd_Req is sampled low; o_Rd_Valid then clears on that edge and o_Rd_Byte keeps its last value.
REQ-026 If i_Rd_Req falls while pending and no byte has been delivered, pending SHALL clear and no pop SHALL occur.
REQ-027 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-028 A push SHALL be accepted when full if a pop occurs on the same edge.
REQ-029 Every pop SHALL read the pre-edge head entry.
REQ-030 A new request SHALL need i_Rd_Req to go low then high again; a held-high level SHALL not pop twice.

Reset
REQ-031 rst low SHALL asynchronously force: FSM = IDLE; counter = 0; pointers = 0; count = 0; pending = 0; o_Rd_Byte = 0x00; o_Rd_Valid = 0; o_Overrun = 0; o_Frame_Err = 0; synchronizer flops = 1; registered request = 0.
REQ-032 A reset mid-frame SHALL abort the frame with no push; after release the FSM SHALL wait for a new falling edge.
REQ-033 FIFO contents SHALL be unaffected by reset; they are unreachable once count = 0.

Verification
REQ-034 Byte delivery: send 0x41 at 50 clk/bit, then pulse i_Rd_Req -> o_Fifo_Count goes 1 then 0; o_Rd_Valid = 1 with o_Rd_Byte = 0x41 two edges after the request; o_Rd_Valid = 0 on the edge after i_Rd_Req falls.
REQ-035 Overrun: send nine bytes 0x01..0x09 with no reads -> o_Fifo_Count = 8 and o_Overrun = 1; eight requests return 0x01..0x08 in order.
REQ-036 Pending request: raise i_Rd_Req while empty, then send 0x5A -> o_Rd_Valid rises with 0x5A one edge after the stop-bit sample; count returns to 0.
REQ-037 Frame error: send 0x33 with the stop bit low -> one-cycle o_Frame_Err; o_Fifo_Count stays 0; the next valid 0x34 is received correctly.
REQ-038 Glitch and reset: a 10-cycle low pulse on the line -> no push. Assert rst during bit 4 of 0x77, release, then send 0x12 -> only 0x12 enters the FIFO and all outputs read reset values during rst.
